// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and default widths for the memory arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWNER_IFU = 1'b0,
      OWNER_LSU = 1'b1
   } owner_t;

   localparam int DEF_ADDR_W = 64;
   localparam int DEF_DATA_W = 64;
   localparam int DEF_MASK_W = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - grant decision; MEM_ARB_RR_EN selects round-robin tie-break
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   i_ifu_valid,
   input  logic   i_lsu_valid,
   input  owner_t i_last_owner,
   output logic   o_grant_ifu,
   output logic   o_grant_lsu
);

   logic w_lsu_wins_tie;

`ifdef MEM_ARB_RR_EN
   // LSU wins a tie only if IFU was granted last
   assign w_lsu_wins_tie = (i_last_owner == OWNER_IFU);
`else
   // Fixed priority: the last-owner input carries no information here
   logic w_unused_last_owner;
   assign w_unused_last_owner = i_last_owner;
   assign w_lsu_wins_tie      = 1'b1;
`endif

   // A lone requester is always granted; a tie is resolved by policy
   always_comb begin
      o_grant_ifu = 1'b0;
      o_grant_lsu = 1'b0;
      if (i_ifu_valid && i_lsu_valid) begin
         o_grant_lsu = w_lsu_wins_tie;
         o_grant_ifu = !w_lsu_wins_tie;
      end else begin
         o_grant_ifu = i_ifu_valid;
         o_grant_lsu = i_lsu_valid;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU single-outstanding memory arbiter; MEM_ARB_RR_EN enables round-robin
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int MASK_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [MASK_W-1:0] lsu_mask,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_mask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            r_state;
   state_t            w_state_nxt;
   owner_t            r_owner;
   owner_t            w_last_owner;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wen;
   logic [DATA_W-1:0] r_wdata;
   logic [MASK_W-1:0] r_mask;
   logic              w_pick_ifu;
   logic              w_pick_lsu;
   logic              w_accept;

   mem_arb_pick u_pick (
      .i_ifu_valid  (ifu_req_valid),
      .i_lsu_valid  (lsu_req_valid),
      .i_last_owner (w_last_owner),
      .o_grant_ifu  (w_pick_ifu),
      .o_grant_lsu  (w_pick_lsu)
   );

   assign w_accept = ifu_req_ready | lsu_req_ready;

`ifdef MEM_ARB_RR_EN
   owner_t r_last_owner;

   // Remember who won the most recent grant so the other side wins the next tie
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_owner <= OWNER_IFU;
      end else if (w_accept) begin
         r_last_owner <= lsu_req_ready ? OWNER_LSU : OWNER_IFU;
      end
   end

   assign w_last_owner = r_last_owner;
`else
   assign w_last_owner = OWNER_IFU;
`endif

   // State register; reset abandons any in-flight transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Capture the granted request; IFU fetches are reads with no write payload
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner <= OWNER_IFU;
         r_addr  <= '0;
         r_wen   <= 1'b0;
         r_wdata <= '0;
         r_mask  <= '0;
      end else if (w_accept) begin
         if (lsu_req_ready) begin
            r_owner <= OWNER_LSU;
            r_addr  <= lsu_addr;
            r_wen   <= lsu_wen;
            r_wdata <= lsu_wdata;
            r_mask  <= lsu_mask;
         end else begin
            r_owner <= OWNER_IFU;
            r_addr  <= ifu_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_mask  <= '0;
         end
      end
   end

   // Next state and outputs; every output is forced low while reset is high
   always_comb begin
      w_state_nxt    = r_state;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      ifu_rdata      = '0;
      lsu_rdata      = '0;
      mem_req_valid  = 1'b0;
      mem_addr       = '0;
      mem_wen        = 1'b0;
      mem_wdata      = '0;
      mem_mask       = '0;
      if (!rst) begin
         case (r_state)
            IDLE: begin
               ifu_req_ready = w_pick_ifu;
               lsu_req_ready = w_pick_lsu;
               if (w_pick_ifu || w_pick_lsu) begin
                  w_state_nxt = REQ;
               end
            end
            REQ: begin
               mem_req_valid = 1'b1;
               mem_addr      = r_addr;
               mem_wen       = r_wen;
               mem_wdata     = r_wdata;
               mem_mask      = r_mask;
               if (mem_req_ready) begin
                  w_state_nxt = RESP;
               end
            end
            RESP: begin
               if (mem_resp_valid) begin
                  w_state_nxt = IDLE;
                  if (r_owner == OWNER_LSU) begin
                     lsu_resp_valid = 1'b1;
                     lsu_rdata      = mem_rdata;
                  end else begin
                     ifu_resp_valid = 1'b1;
                     ifu_rdata      = mem_rdata;
                  end
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (honours MEM_ARB_RR_EN)
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
   logic [63:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
   logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [7:0]  lsu_mask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_mask;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        ifu_v;
      logic        lsu_v;
      logic        lsu_wen;
      logic [63:0] ifu_addr;
      logic [63:0] lsu_addr;
      logic [63:0] wdata;
      logic [7:0]  mask;
      int          wait_cyc;
      logic [63:0] rdata;
      logic        exp_lsu;
   } vec_t;

   typedef struct {
      logic        lsu;
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  mask;
      logic [63:0] rdata;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[7];

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_addr       (ifu_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_rdata      (ifu_rdata),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_addr       (lsu_addr),
      .lsu_wen        (lsu_wen),
      .lsu_wdata      (lsu_wdata),
      .lsu_mask       (lsu_mask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_rdata      (lsu_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_wen        (mem_wen),
      .mem_wdata      (mem_wdata),
      .mem_mask       (mem_mask),
      .mem_resp_valid (mem_resp_valid),
      .mem_rdata      (mem_rdata)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #5;
   endtask

   function automatic vec_t mk(input logic iv, input logic lv, input logic wen,
                               input logic [63:0] ia, input logic [63:0] la,
                               input logic [63:0] wd, input logic [7:0] mk_mask,
                               input int wc, input logic [63:0] rd, input logic exp_lsu);
      vec_t v;
      v.ifu_v = iv; v.lsu_v = lv; v.lsu_wen = wen; v.ifu_addr = ia; v.lsu_addr = la;
      v.wdata = wd; v.mask = mk_mask; v.wait_cyc = wc; v.rdata = rd; v.exp_lsu = exp_lsu;
      return v;
   endfunction

   task automatic apply_req(input vec_t v);
      ifu_req_valid = v.ifu_v;
      ifu_addr      = v.ifu_addr;
      lsu_req_valid = v.lsu_v;
      lsu_addr      = v.lsu_addr;
      lsu_wen       = v.lsu_wen;
      lsu_wdata     = v.wdata;
      lsu_mask      = v.mask;
   endtask

   task automatic clear_req();
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, {ifu_req_ready, lsu_req_ready}, 0);
      chk({tag, "_resp_valid"}, {ifu_resp_valid, lsu_resp_valid}, 0);
      chk({tag, "_ifu_rdata"}, ifu_rdata, 0);
      chk({tag, "_lsu_rdata"}, lsu_rdata, 0);
      chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wen_mask"}, {mem_wen, mem_mask}, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
   endtask

   // Request inputs of v are already applied at the start of the current cycle
   task automatic run_vec(input vec_t v, input bit chk_lat, input bit has_nxt, input vec_t nxt);
      int   waited = 0;
      exp_t e;
      settle();
      while (!(ifu_req_ready || lsu_req_ready) && waited < 20) begin
         cyc();
         settle();
         waited++;
      end
      if (chk_lat) chk("accept_latency", waited, 0);
      chk("grant_lsu", lsu_req_ready, v.exp_lsu);
      chk("grant_ifu", ifu_req_ready, !v.exp_lsu);
      if (waited >= 20) return;
      chk("accept_no_mem_req", mem_req_valid, 0);
      e.lsu   = v.exp_lsu;
      e.addr  = v.exp_lsu ? v.lsu_addr : v.ifu_addr;
      e.wen   = v.exp_lsu ? v.lsu_wen : 1'b0;
      e.wdata = v.exp_lsu ? v.wdata : 64'h0;
      e.mask  = v.exp_lsu ? v.mask : 8'h0;
      e.rdata = v.rdata;
      sb.push_back(e);
      cyc();
      if (has_nxt) apply_req(nxt);
      else clear_req();
      for (int k = 0; k <= v.wait_cyc; k++) begin
         mem_req_ready = (k == v.wait_cyc);
         settle();
         chk("mem_req_valid", mem_req_valid, 1);
         chk("mem_addr", mem_addr, e.addr);
         chk("mem_wen", mem_wen, e.wen);
         chk("mem_wdata", mem_wdata, e.wdata);
         chk("mem_mask", mem_mask, e.mask);
         chk("busy_ready", {ifu_req_ready, lsu_req_ready}, 0);
         chk("req_resp_quiet", {ifu_resp_valid, lsu_resp_valid}, 0);
         cyc();
      end
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = v.rdata;
      settle();
      chk("resp_mem_req_valid", mem_req_valid, 0);
      chk("resp_busy_ready", {ifu_req_ready, lsu_req_ready}, 0);
      if (ifu_resp_valid || lsu_resp_valid) begin
         if (sb.size() == 0) begin
            chk("scoreboard_unexpected_resp", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("ifu_resp_valid", ifu_resp_valid, !e.lsu);
            chk("lsu_resp_valid", lsu_resp_valid, e.lsu);
            chk("ifu_rdata", ifu_rdata, e.lsu ? 64'h0 : e.rdata);
            chk("lsu_rdata", lsu_rdata, e.lsu ? e.rdata : 64'h0);
         end
      end else begin
         chk("resp_missing", 0, 1);
         void'(sb.pop_front());
      end
      cyc();
      mem_resp_valid = 1'b0;
      mem_rdata      = 64'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic tie_exp[4];
      vec_t none;
      vec_t t;
      vec_t ifu_v;
`ifdef MEM_ARB_RR_EN
      tie_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      tie_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         vecs[i] = mk(1, 1, 0, 64'h8000_0200 + 64'(i * 8), 64'h8000_3000 + 64'(i * 16),
                      64'h0, 8'h00, 0, 64'h1111_0000 + 64'(i), tie_exp[i]);
      end
      vecs[4] = mk(1, 0, 0, 64'h8000_0000, 0, 0, 0, 0, 64'h0000_0013, 0);
      vecs[5] = mk(0, 1, 1, 0, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 3, 64'h0, 1);
      vecs[6] = mk(0, 1, 0, 0, 64'h8000_1008, 64'h5555, 8'hFF, 1, 64'hCAFE_F00D_1234_5678, 1);

      rst            = 1'b1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = 64'h0;
      apply_req(none);
      cyc();
      cyc();
      // requests raised while reset is high must not be granted
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      settle();
      chk_all_zero("reset");
      cyc();
      clear_req();
      rst = 1'b0;
      settle();
      chk_all_zero("post_reset_idle");
      cyc();

      apply_req(vecs[0]);
      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], i > 0, i < 6, (i < 6) ? vecs[i + 1] : none);
      end

      // spurious response in IDLE
      mem_resp_valid = 1'b1;
      mem_rdata      = 64'hBAD0_BAD0;
      settle();
      chk_all_zero("spurious");
      cyc();
      mem_resp_valid = 1'b0;
      mem_rdata      = 64'h0;
      settle();
      chk("spurious_still_idle", mem_req_valid, 0);
      cyc();
      ifu_v = mk(1, 0, 0, 64'h8000_0040, 0, 0, 0, 0, 64'h77, 0);
      apply_req(ifu_v);
      run_vec(ifu_v, 1, 0, none);

      // reset while an LSU load sits in RESP
      apply_req(mk(0, 1, 0, 0, 64'h8000_2000, 0, 0, 0, 0, 1));
      settle();
      chk("midrst_grant_lsu", lsu_req_ready, 1);
      cyc();
      clear_req();
      mem_req_ready = 1'b1;
      settle();
      chk("midrst_mem_req_valid", mem_req_valid, 1);
      cyc();
      mem_req_ready = 1'b0;
      rst           = 1'b1;
      settle();
      chk_all_zero("midrst_in_reset");
      cyc();
      rst            = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = 64'h9999;
      settle();
      chk_all_zero("midrst_late_resp");
      cyc();
      mem_resp_valid = 1'b0;
      mem_rdata      = 64'h0;
      // pointer was cleared to IFU, so LSU wins this tie in either policy
      t     = mk(1, 1, 0, 64'h8000_0080, 64'h8000_4000, 0, 0, 0, 64'h4242, 1);
      ifu_v = mk(1, 0, 0, 64'h8000_0084, 0, 0, 0, 0, 64'h0000_0093, 0);
      apply_req(t);
      run_vec(t, 1, 1, ifu_v);
      run_vec(ifu_v, 1, 0, none);

      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
